// File: rtl/pipe_skid_reg.sv
// Valid/ready pipeline stage with a registered in_ready and a main+skid buffer.
// Also provides a synchronous flush and a saturating stall counter.
module pipe_skid_reg #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             acc, drn;

  // in_ready comes straight from the state register, so out_ready never reaches it.
  assign in_ready    = (state_q != FULL);
  assign out_valid   = (state_q != EMPTY);
  assign out_data    = main_q;
  assign stall_count = stall_q;

  assign acc = in_valid & in_ready;
  assign drn = out_valid & out_ready;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            main_d  = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (acc && drn) begin
            main_d = in_data;
          end else if (acc) begin
            skid_d  = in_data;
            state_d = FULL;
          end else if (drn) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (drn) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (clr_stats) begin
      stall_d = '0;
    end else if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // NOTE: the payload registers are reset too, so out_data reads 0 straight after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      stall_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: vector table, queue scoreboard,
// stall-counter saturation on a narrow instance and asynchronous reset.
module tb_pipe_skid_reg;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        clr_stats = 1'b0;
  logic [15:0] stall_count;

  logic        flush4 = 1'b0;
  logic        in_valid4 = 1'b0;
  logic        in_ready4;
  logic [7:0]  in_data4 = '0;
  logic        out_valid4;
  logic        out_ready4 = 1'b0;
  logic [7:0]  out_data4;
  logic        clr_stats4 = 1'b0;
  logic [3:0]  stall_count4;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  logic [31:0] exp_q[$];
  logic [15:0] exp_stall;

  always #5 clk = ~clk;

  pipe_skid_reg dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .clr_stats(clr_stats), .stall_count(stall_count)
  );

  pipe_skid_reg #(.WIDTH(8), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .flush(flush4),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
    .clr_stats(clr_stats4), .stall_count(stall_count4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a two-deep FIFO plus a saturating stall counter.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q.delete();
      exp_stall = '0;
    end else begin
      automatic bit m_ir  = (exp_q.size() < 2);
      automatic bit m_ov  = (exp_q.size() > 0);
      automatic bit m_drn = m_ov && out_ready;
      automatic bit m_acc = in_valid && m_ir;
      if (clr_stats) exp_stall = '0;
      else if (m_ov && !out_ready && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
      if (m_drn) void'(exp_q.pop_front());
      if (flush) exp_q.delete();
      else if (m_acc) exp_q.push_back(in_data);
    end
  end

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("sb_out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() > 0});
      check("sb_in_ready", {31'b0, in_ready}, {31'b0, exp_q.size() < 2});
      check("sb_stall_count", {16'b0, stall_count}, {16'b0, exp_stall});
      if (exp_q.size() > 0) check("sb_out_data", out_data, exp_q[0]);
    end
  end

  typedef struct {
    string       name;
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        fl;
    logic        ov;
    logic        ir;
    logic [31:0] od;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{"first_beat",  1'b1, 32'h13, 1'b1, 1'b0, 1'b1, 1'b1, 32'h13});
    vecs.push_back('{"stream_1",    1'b1, 32'h1,  1'b1, 1'b0, 1'b1, 1'b1, 32'h1});
    vecs.push_back('{"stream_2",    1'b1, 32'h2,  1'b1, 1'b0, 1'b1, 1'b1, 32'h2});
    vecs.push_back('{"stream_3",    1'b1, 32'h3,  1'b1, 1'b0, 1'b1, 1'b1, 32'h3});
    vecs.push_back('{"stream_4",    1'b1, 32'h4,  1'b1, 1'b0, 1'b1, 1'b1, 32'h4});
    vecs.push_back('{"drain_empty", 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 32'h4});
    vecs.push_back('{"load_a",      1'b1, 32'hA,  1'b0, 1'b0, 1'b1, 1'b1, 32'hA});
    vecs.push_back('{"fill_b",      1'b1, 32'hB,  1'b0, 1'b0, 1'b1, 1'b0, 32'hA});
    vecs.push_back('{"full_hold",   1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 32'hA});
    vecs.push_back('{"drain_a",     1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'hB});
    vecs.push_back('{"drain_b",     1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 32'hB});
    vecs.push_back('{"reload_a",    1'b1, 32'hA,  1'b0, 1'b0, 1'b1, 1'b1, 32'hA});
    vecs.push_back('{"refill_b",    1'b1, 32'hB,  1'b0, 1'b0, 1'b1, 1'b0, 32'hA});
    vecs.push_back('{"flush_full",  1'b1, 32'hC,  1'b0, 1'b1, 1'b0, 1'b1, 32'h0});
    vecs.push_back('{"after_flush", 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 32'h0});
    vecs.push_back('{"load_d",      1'b1, 32'hD,  1'b0, 1'b0, 1'b1, 1'b1, 32'hD});
    vecs.push_back('{"flush_drain", 1'b1, 32'hE,  1'b1, 1'b1, 1'b0, 1'b1, 32'h0});

    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_data", out_data, 32'd0);
    check("rst_stall_count", {16'b0, stall_count}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;

    foreach (vecs[i]) begin
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].d;
      out_ready = vecs[i].ordy;
      flush     = vecs[i].fl;
      @(posedge clk);
      #1;
      check({vecs[i].name, "_out_valid"}, {31'b0, out_valid}, {31'b0, vecs[i].ov});
      check({vecs[i].name, "_in_ready"}, {31'b0, in_ready}, {31'b0, vecs[i].ir});
      check({vecs[i].name, "_out_data"}, out_data, vecs[i].od);
    end
    in_valid = 1'b0;
    flush    = 1'b0;

    // Stall counter keeps counting and honours clr_stats over increment.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h55;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    clr_stats = 1'b1;
    @(posedge clk); #1;
    clr_stats = 1'b0;
    check("clr_main", {16'b0, stall_count}, 32'd0);
    @(posedge clk); #1;
    check("clr_resume_main", {16'b0, stall_count}, 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Narrow counter saturates at 0xF.
    in_valid4 = 1'b1; in_data4 = 8'h5A;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    check("n4_loaded", {31'b0, out_valid4}, 32'd1);
    repeat (20) @(posedge clk);
    #1;
    check("n4_saturate", {28'b0, stall_count4}, 32'hF);
    check("n4_data_hold", {24'b0, out_data4}, 32'h5A);
    clr_stats4 = 1'b1;
    @(posedge clk); #1;
    clr_stats4 = 1'b0;
    check("n4_clear", {28'b0, stall_count4}, 32'h0);
    @(posedge clk); #1;
    check("n4_resume", {28'b0, stall_count4}, 32'h1);

    // Fill to FULL, then assert reset between clock edges.
    in_valid = 1'b1; in_data = 32'hA;
    @(posedge clk); #1;
    in_data = 32'hB;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre_rst_full", {31'b0, in_ready}, 32'd0);
    #2 reset = 1'b1;
    #1;
    check("arst_out_valid", {31'b0, out_valid}, 32'd0);
    check("arst_in_ready", {31'b0, in_ready}, 32'd1);
    check("arst_out_data", out_data, 32'd0);
    check("arst_stall_count", {16'b0, stall_count}, 32'd0);
    check("arst_stall_count4", {28'b0, stall_count4}, 32'd0);
    reset = 1'b0;

    // Post-reset sanity: stream a few beats with randomised backpressure.
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (!(in_valid && !in_ready)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = $urandom;
      end
      out_ready = ($urandom_range(0, 2) != 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("final_empty", {31'b0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
